// File: rtl/scsu_ocp_pkg.sv
//------------------------------------------------------------------------------
// Module : scsu_ocp_pkg
// Brief  : OCP command/response encodings, FSM state type and error data word
//          shared by the SCSU OCP master bridge.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package scsu_ocp_pkg;

    localparam logic [2:0] c_mcmd_idle = 3'd0;
    localparam logic [2:0] c_mcmd_wr   = 3'd1;
    localparam logic [2:0] c_mcmd_rd   = 3'd2;

    localparam logic [1:0] c_sresp_null = 2'd0;
    localparam logic [1:0] c_sresp_dva  = 2'd1;
    localparam logic [1:0] c_sresp_err  = 2'd3;

    localparam logic [15:0] c_err_data = 16'hDEAD;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/scsu_ocp_mst.sv
//------------------------------------------------------------------------------
// Module : scsu_ocp_mst
// Brief  : Bridges the SCS16 external-bus request/done handshake onto a single
//          outstanding OCP master transaction (posted writes, reads with
//          response). Optional watchdog enabled by SCSU_OCP_TIMEOUT_EN.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module scsu_ocp_mst
    import scsu_ocp_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scs16_ext_bus_cs,
    input  logic [1:0]  scs16_ram_we,
    input  logic [23:0] scs16_ram_addr,
    input  logic [15:0] scs16_ram_wr_data,
    output logic        scs16_ext_bus_done,
    output logic [15:0] scs16_ext_rd_data,
    output logic [2:0]  scsu_m_ocp_mcmd,
    output logic [1:0]  scsu_m_ocp_mbyten,
    output logic [12:0] scsu_m_ocp_maddr,
    output logic [15:0] scsu_m_ocp_mdata,
    input  logic        ocp_scsu_m_scmdaccept,
    input  logic [1:0]  ocp_scsu_m_sresp,
    input  logic [15:0] ocp_scsu_m_sdata,
    output logic        bus_err,
    input  logic        bus_err_clr
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_prev_done;
    logic        r_is_wr;
    logic        w_is_wr_nxt;
    logic [2:0]  r_mcmd;
    logic [2:0]  w_mcmd_nxt;
    logic [1:0]  r_mbyten;
    logic [1:0]  w_mbyten_nxt;
    logic [12:0] r_maddr;
    logic [12:0] w_maddr_nxt;
    logic [15:0] r_mdata;
    logic [15:0] w_mdata_nxt;
    logic        r_done;
    logic        w_done_nxt;
    logic [15:0] r_rd_data;
    logic [15:0] w_rd_data_nxt;
    logic        r_bus_err;
    logic        w_err_set;
    logic        w_to_hit;
    logic        w_busy;

    assign w_busy = (r_state == ST_CMD) || (r_state == ST_RESP);

`ifdef SCSU_OCP_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] r_to_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_cnt <= '0;
        end else if (r_state == ST_IDLE && w_state_nxt == ST_CMD) begin
            r_to_cnt <= '0;
        end else if (w_busy) begin
            r_to_cnt <= r_to_cnt + CNT_W'(1);
        end
    end

    // Count value at the edge closing the TIMEOUT_CYCLES-th busy cycle.
    assign w_to_hit = w_busy && (r_to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic w_unused_to_cfg;
    assign w_unused_to_cfg = |TIMEOUT_CYCLES;
    assign w_to_hit        = 1'b0;
`endif

    logic w_unused_addr;
    assign w_unused_addr = ^{scs16_ram_addr[23:14], scs16_ram_addr[0]};

    always_comb begin
        w_state_nxt   = r_state;
        w_is_wr_nxt   = r_is_wr;
        w_mcmd_nxt    = r_mcmd;
        w_mbyten_nxt  = r_mbyten;
        w_maddr_nxt   = r_maddr;
        w_mdata_nxt   = r_mdata;
        w_done_nxt    = 1'b0;
        w_rd_data_nxt = r_rd_data;
        w_err_set     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_mcmd_nxt = c_mcmd_idle;
                // The request level is still high right after a completion.
                if (scs16_ext_bus_cs && !r_prev_done) begin
                    w_state_nxt  = ST_CMD;
                    w_is_wr_nxt  = (scs16_ram_we != 2'b00);
                    w_mcmd_nxt   = (scs16_ram_we != 2'b00) ? c_mcmd_wr : c_mcmd_rd;
                    w_mbyten_nxt = (scs16_ram_we != 2'b00) ? scs16_ram_we : 2'b11;
                    w_maddr_nxt  = scs16_ram_addr[13:1];
                    w_mdata_nxt  = scs16_ram_wr_data;
                end
            end

            ST_CMD: begin
                if (ocp_scsu_m_scmdaccept) begin
                    w_mcmd_nxt = c_mcmd_idle;
                    if (r_is_wr) begin
                        w_state_nxt = ST_DONE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = ST_RESP;
                    end
                end else if (w_to_hit) begin
                    w_mcmd_nxt    = c_mcmd_idle;
                    w_state_nxt   = ST_DONE;
                    w_done_nxt    = 1'b1;
                    w_rd_data_nxt = c_err_data;
                    w_err_set     = 1'b1;
                end
            end

            ST_RESP: begin
                if (ocp_scsu_m_sresp == c_sresp_dva) begin
                    w_state_nxt   = ST_DONE;
                    w_done_nxt    = 1'b1;
                    w_rd_data_nxt = ocp_scsu_m_sdata;
                end else if (ocp_scsu_m_sresp != c_sresp_null || w_to_hit) begin
                    // Reserved code 2 is handled as an error response.
                    w_state_nxt   = ST_DONE;
                    w_done_nxt    = 1'b1;
                    w_rd_data_nxt = c_err_data;
                    w_err_set     = 1'b1;
                end
            end

            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_mcmd_nxt  = c_mcmd_idle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_prev_done <= 1'b0;
            r_is_wr     <= 1'b0;
            r_mcmd      <= c_mcmd_idle;
            r_mbyten    <= 2'b00;
            r_maddr     <= 13'd0;
            r_mdata     <= 16'd0;
            r_done      <= 1'b0;
            r_rd_data   <= 16'd0;
            r_bus_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_prev_done <= (r_state == ST_DONE);
            r_is_wr     <= w_is_wr_nxt;
            r_mcmd      <= w_mcmd_nxt;
            r_mbyten    <= w_mbyten_nxt;
            r_maddr     <= w_maddr_nxt;
            r_mdata     <= w_mdata_nxt;
            r_done      <= w_done_nxt;
            r_rd_data   <= w_rd_data_nxt;
            if (w_err_set) begin
                r_bus_err <= 1'b1;
            end else if (bus_err_clr) begin
                r_bus_err <= 1'b0;
            end
        end
    end

    assign scs16_ext_bus_done = r_done;
    assign scs16_ext_rd_data  = r_rd_data;
    assign scsu_m_ocp_mcmd    = r_mcmd;
    assign scsu_m_ocp_mbyten  = r_mbyten;
    assign scsu_m_ocp_maddr   = r_maddr;
    assign scsu_m_ocp_mdata   = r_mdata;
    assign bus_err            = r_bus_err;

endmodule

`default_nettype wire

// File: tb/tb_scsu_ocp_mst.sv
//------------------------------------------------------------------------------
// Module : tb_scsu_ocp_mst
// Brief  : Self-checking bench for scsu_ocp_mst; per-transaction timing model
//          with randomized slave delays, responses and noise.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_scsu_ocp_mst;

    localparam int TB_TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        cs;
    logic [1:0]  we;
    logic [23:0] addr;
    logic [15:0] wdata;
    logic        done;
    logic [15:0] rd_data;
    logic [2:0]  mcmd;
    logic [1:0]  mbyten;
    logic [12:0] maddr;
    logic [15:0] mdata;
    logic        accept;
    logic [1:0]  sresp;
    logic [15:0] sdata;
    logic        berr;
    logic        berr_clr;

    int          n_total = 0;
    int          n_bad   = 0;
    logic [15:0] exp_rd;
    logic        exp_err;

    scsu_ocp_mst #(.TIMEOUT_CYCLES(TB_TO)) u_dut (
        .clk                   (clk),
        .rst                   (rst),
        .scs16_ext_bus_cs      (cs),
        .scs16_ram_we          (we),
        .scs16_ram_addr        (addr),
        .scs16_ram_wr_data     (wdata),
        .scs16_ext_bus_done    (done),
        .scs16_ext_rd_data     (rd_data),
        .scsu_m_ocp_mcmd       (mcmd),
        .scsu_m_ocp_mbyten     (mbyten),
        .scsu_m_ocp_maddr      (maddr),
        .scsu_m_ocp_mdata      (mdata),
        .ocp_scsu_m_scmdaccept (accept),
        .ocp_scsu_m_sresp      (sresp),
        .ocp_scsu_m_sdata      (sdata),
        .bus_err               (berr),
        .bus_err_clr           (berr_clr)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One core request. Edge 0 samples cs; the slave accepts at edge A+1, a
    // read response arrives at edge A+2+R. With tmo the slave never accepts.
    // clr_mode: 0 never clear, 1 random clears, 2 clear every cycle.
    task automatic run_txn(input bit wr, input logic [1:0] twe, input logic [23:0] taddr,
                           input logic [15:0] twd, input int A, input int R,
                           input logic [1:0] resp, input logic [15:0] sdat,
                           input bit extra_cs, input int clr_mode, input bit tmo);
        int         fin;
        logic [2:0] cmd;
        logic       clr_t;
        bit         err_evt;
        bit         in_cmd;
        cmd = wr ? 3'd1 : 3'd2;
        fin = tmo ? TB_TO : (wr ? A + 1 : A + 2 + R);
        for (int t = 0; t <= fin + 2; t++) begin
            cs    = (t <= fin + 1) || (extra_cs && t == fin + 2);
            we    = twe;
            addr  = taddr;
            wdata = twd;
            in_cmd = tmo ? (t >= 1 && t <= fin) : (t >= 1 && t <= A);
            if (in_cmd)                 accept = 1'b0;
            else if (!tmo && t == A + 1) accept = 1'b1;
            else                        accept = 1'($urandom_range(1));
            if (!wr && !tmo && t >= A + 2 && t < fin) sresp = 2'd0;
            else if (!wr && !tmo && t == fin)         sresp = resp;
            else                                      sresp = 2'($urandom_range(3));
            sdata = (t == fin) ? sdat : 16'($urandom);
            clr_t = (clr_mode == 2) || (clr_mode == 1 && $urandom_range(3) == 0);
            berr_clr = clr_t;
            tick();
            err_evt = (t == fin) && (tmo || (!wr && resp != 2'd1));
            if (err_evt)    exp_err = 1'b1;
            else if (clr_t) exp_err = 1'b0;
            if (t == fin) begin
                if (err_evt)  exp_rd = 16'hDEAD;
                else if (!wr) exp_rd = sdat;
            end
            check_val("mcmd", 32'(mcmd), ((tmo ? t < fin : t <= A) ? 32'(cmd) : 32'd0));
            check_val("done", 32'(done), 32'(t == fin));
            check_val("bus_err", 32'(berr), 32'(exp_err));
            check_val("rd_data", 32'(rd_data), 32'(exp_rd));
            if (t == 0) begin
                check_val("maddr", 32'(maddr), 32'(taddr[13:1]));
                check_val("mbyten", 32'(mbyten), wr ? 32'(twe) : 32'd3);
                if (wr) check_val("mdata", 32'(mdata), 32'(twd));
            end
        end
        cs       = 1'b0;
        berr_clr = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_mcmd"}, 32'(mcmd), 32'd0);
        check_val({tag, "_done"}, 32'(done), 32'd0);
        check_val({tag, "_rd"}, 32'(rd_data), 32'd0);
        check_val({tag, "_err"}, 32'(berr), 32'd0);
        check_val({tag, "_maddr"}, 32'(maddr), 32'd0);
        check_val({tag, "_mbyten"}, 32'(mbyten), 32'd0);
        check_val({tag, "_mdata"}, 32'(mdata), 32'd0);
    endtask

    initial begin
        int  n_done;
        bit  wr;
        logic [1:0] rsp;
        rst = 1'b1; cs = 1'b0; we = 2'b00; addr = 24'd0; wdata = 16'd0;
        accept = 1'b0; sresp = 2'd0; sdata = 16'd0; berr_clr = 1'b0;
        exp_rd = 16'd0; exp_err = 1'b0;
        #2;
        check_reset_outputs("por");
        tick(); tick();
        rst = 1'b0;
        tick();

        // Directed: posted write, immediate accept.
        run_txn(1'b1, 2'b11, 24'h000124, 16'hA5A5, 0, 0, 2'd0, 16'h0, 1'b0, 0, 1'b0);
        // Directed: read with accept wait 3 and one NULL cycle before DVA.
        run_txn(1'b0, 2'b00, 24'h000010, 16'h0, 3, 1, 2'd1, 16'h1234, 1'b0, 0, 1'b0);
        // Directed: error read, then explicit clear.
        run_txn(1'b0, 2'b00, 24'h000200, 16'h0, 1, 0, 2'd3, 16'h5555, 1'b0, 0, 1'b0);
        berr_clr = 1'b1;
        tick();
        berr_clr = 1'b0;
        exp_err = 1'b0;
        check_val("err_clr", 32'(berr), 32'd0);
        // Directed: clear held every cycle while an error lands (set wins).
        run_txn(1'b0, 2'b00, 24'h000300, 16'h0, 0, 2, 2'd2, 16'h0, 1'b1, 2, 1'b0);
        // Directed: write leaves read data alone, cs held an extra cycle.
        run_txn(1'b1, 2'b01, 24'h000FFE, 16'h0F0F, 2, 0, 2'd0, 16'h0, 1'b1, 0, 1'b0);

        // Reset while waiting in RESP.
        cs = 1'b1; we = 2'b00; addr = 24'h000040; accept = 1'b0; sresp = 2'd0;
        tick();
        accept = 1'b1;
        tick();
        accept = 1'b0;
        tick();
        check_val("pre_rst_mcmd", 32'(mcmd), 32'd0);
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_resp");
        exp_rd = 16'd0; exp_err = 1'b0;
        cs = 1'b0;
        tick();
        rst = 1'b0;
        n_done = 0;
        for (int i = 0; i < 4; i++) begin
            sresp = 2'd1;
            tick();
            if (done) n_done++;
        end
        check_val("rst_no_done", 32'(n_done), 32'd0);
        sresp = 2'd0;
        run_txn(1'b0, 2'b00, 24'h000082, 16'h0, 0, 0, 2'd1, 16'hBEEF, 1'b0, 0, 1'b0);

`ifdef SCSU_OCP_TIMEOUT_EN
        run_txn(1'b0, 2'b00, 24'h000400, 16'h0, 0, 0, 2'd0, 16'h0, 1'b0, 0, 1'b1);
        run_txn(1'b1, 2'b10, 24'h000402, 16'h7777, 0, 0, 2'd0, 16'h0, 1'b0, 1, 1'b1);
`else
        // Slave that never accepts: the bridge must wait without completing.
        cs = 1'b1; we = 2'b00; addr = 24'h000400; accept = 1'b0;
        n_done = 0;
        for (int i = 0; i < 1000; i++) begin
            sresp = 2'($urandom_range(3));
            tick();
            if (done) n_done++;
        end
        check_val("hang_no_done", 32'(n_done), 32'd0);
        check_val("hang_mcmd", 32'(mcmd), 32'd2);
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_cmd");
        exp_rd = 16'd0; exp_err = 1'b0;
        cs = 1'b0; sresp = 2'd0;
        tick();
        rst = 1'b0;
        tick();
`endif

        for (int n = 0; n < 40; n++) begin
            wr = 1'($urandom_range(1));
            case ($urandom_range(3))
                0, 1:    rsp = 2'd1;
                2:       rsp = 2'd2;
                default: rsp = 2'd3;
            endcase
            run_txn(wr, wr ? 2'($urandom_range(3, 1)) : 2'b00, 24'($urandom),
                    16'($urandom), int'($urandom_range(2)), int'($urandom_range(2)),
                    rsp, 16'($urandom), 1'($urandom_range(1)), 1, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
